debug_probe_scan: RTL and testbench

Parametrised debug-display selector for the pipelined MIPS board top: it takes CHANNELS probe words (PC, instruction, ALU result, control bundles, etc.) and drives one registered WIDTH-bit display word. On top of the existing static channel select, it adds three capabilities:

- a freeze (HOLD) mode that snapshots every channel at once;
- an auto-scan mode that rotates through the channels;
- a trigger-armed capture mode for catching a pipeline state on an event.

---
 rtl/debug_probe_scan.sv | 130 +++++++++++++
 tb/tb_debug_probe_scan.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/debug_probe_scan.sv
// Debug display selector: live channel select, frozen snapshot, auto-scan and
// trigger-armed capture, driving one registered display word.
module debug_probe_scan #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 1000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] probe_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic [1:0]                mode,
    input  logic                      trig,
    input  logic                      rearm,
    output logic [WIDTH-1:0]          disdata,
    output logic [SEL_W-1:0]          cur_ch,
    output logic                      capture_valid
);
    // LIVE: probe[sel] | HOLD: snap[sel] | SCAN: probe[idx] rotating |
    // ARMED: live, waiting for trig | CAPTURED: snap[sel], waiting for rearm
    localparam logic [2:0] ST_LIVE     = 3'd0;
    localparam logic [2:0] ST_HOLD     = 3'd1;
    localparam logic [2:0] ST_SCAN     = 3'd2;
    localparam logic [2:0] ST_ARMED    = 3'd3;
    localparam logic [2:0] ST_CAPTURED = 3'd4;

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [WIDTH-1:0] probe_ch [CHANNELS];
    logic [WIDTH-1:0] snap_q   [CHANNELS];
    logic [2:0]       state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] es, src_ch, cur_ch_d;
    logic [WIDTH-1:0] disdata_d;
    logic             capture, use_snap, valid_d;

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            probe_ch[k] = probe_in[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        es = ({{(32-SEL_W){1'b0}}, sel} < 32'(CHANNELS)) ? sel : '0;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        use_snap = 1'b0;
        valid_d  = 1'b0;
        src_ch   = es;
        cur_ch_d = es;
        case (mode)
            2'b00: state_d = ST_LIVE;
            2'b01: begin
                state_d  = ST_HOLD;
                capture  = (state_q != ST_HOLD);
                use_snap = (state_q == ST_HOLD);
            end
            2'b10: begin
                state_d = ST_SCAN;
                if (state_q != ST_SCAN) begin
                    idx_d = '0;
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(DWELL-1)) begin
                    cnt_d = '0;
                    idx_d = (idx_q == SEL_W'(CHANNELS-1)) ? '0 : idx_q + SEL_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                src_ch   = idx_d;
                cur_ch_d = idx_d;
            end
            default: begin
                if (state_q == ST_ARMED) begin
                    if (trig) begin
                        capture = 1'b1;
                        state_d = ST_CAPTURED;
                        valid_d = 1'b1;
                    end
                end else if (state_q == ST_CAPTURED) begin
                    valid_d = 1'b1;
                    if (trig && rearm) begin
                        capture = 1'b1;
                    end else if (rearm) begin
                        state_d = ST_ARMED;
                        valid_d = 1'b0;
                    end else begin
                        use_snap = 1'b1;
                    end
                end else begin
                    state_d = ST_ARMED;
                end
            end
        endcase
        // On a capture edge the live word equals the freshly loaded snapshot.
        disdata_d = use_snap ? snap_q[es] : probe_ch[src_ch];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_LIVE;
            idx_q         <= '0;
            cnt_q         <= '0;
            disdata       <= '0;
            cur_ch        <= '0;
            capture_valid <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                snap_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            disdata       <= disdata_d;
            cur_ch        <= cur_ch_d;
            capture_valid <= valid_d;
            if (capture) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    snap_q[k] <= probe_ch[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_debug_probe_scan.sv
// Directed bench for debug_probe_scan: vector table for LIVE/HOLD/SCAN/TRIG
// plus hand-written reset and out-of-range select sequences.
module tb_debug_probe_scan;
    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] probe_in;
    logic [1:0]   sel, mode;
    logic         trig, rearm;
    logic [31:0]  disdata, disdata3;
    logic [1:0]   cur_ch, cur_ch3;
    logic         capture_valid, capture_valid3;
    logic [31:0]  cyc = 32'd0;
    logic [31:0]  base;
    int           checks = 0;
    int           failures = 0;

    typedef struct {
        logic [1:0] mode;
        logic [1:0] sel;
        logic       trig;
        logic       rearm;
        logic [1:0] ch;
        int         smp;
        logic       valid;
    } vec_t;
    vec_t tbl [34];

    debug_probe_scan #(.WIDTH(32), .CHANNELS(4), .SEL_W(2), .DWELL(3)) dut (
        .clk(clk), .reset(reset), .probe_in(probe_in), .sel(sel), .mode(mode),
        .trig(trig), .rearm(rearm), .disdata(disdata), .cur_ch(cur_ch),
        .capture_valid(capture_valid)
    );

    debug_probe_scan #(.WIDTH(32), .CHANNELS(3), .SEL_W(2), .DWELL(3)) dut3 (
        .clk(clk), .reset(reset), .probe_in(probe_in[95:0]), .sel(sel), .mode(mode),
        .trig(trig), .rearm(rearm), .disdata(disdata3), .cur_ch(cur_ch3),
        .capture_valid(capture_valid3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            probe_in[k*32 +: 32] = (32'(k + 1) << 28) + cyc;
        end
    end

    function automatic logic [31:0] word(input logic [1:0] ch, input logic [31:0] c);
        return (32'({30'd0, ch} + 32'd1) << 28) + c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [1:0] es3;
        //           mode  sel   trig  rearm ch   smp valid
        tbl[0]  = '{2'd0, 2'd2, 1'b0, 1'b0, 2'd2, 0,  1'b0};
        tbl[1]  = '{2'd0, 2'd3, 1'b0, 1'b0, 2'd3, 1,  1'b0};
        tbl[2]  = '{2'd1, 2'd1, 1'b0, 1'b0, 2'd1, 2,  1'b0};
        tbl[3]  = '{2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 2,  1'b0};
        tbl[4]  = '{2'd1, 2'd1, 1'b0, 1'b0, 2'd1, 2,  1'b0};
        tbl[5]  = '{2'd1, 2'd2, 1'b0, 1'b0, 2'd2, 2,  1'b0};
        tbl[6]  = '{2'd1, 2'd3, 1'b0, 1'b0, 2'd3, 2,  1'b0};
        tbl[7]  = '{2'd0, 2'd1, 1'b0, 1'b0, 2'd1, 7,  1'b0};
        tbl[8]  = '{2'd2, 2'd3, 1'b0, 1'b0, 2'd0, 8,  1'b0};
        tbl[9]  = '{2'd2, 2'd1, 1'b0, 1'b0, 2'd0, 9,  1'b0};
        tbl[10] = '{2'd2, 2'd2, 1'b0, 1'b0, 2'd0, 10, 1'b0};
        tbl[11] = '{2'd2, 2'd0, 1'b0, 1'b0, 2'd1, 11, 1'b0};
        tbl[12] = '{2'd2, 2'd3, 1'b0, 1'b0, 2'd1, 12, 1'b0};
        tbl[13] = '{2'd2, 2'd2, 1'b0, 1'b0, 2'd1, 13, 1'b0};
        tbl[14] = '{2'd2, 2'd1, 1'b0, 1'b0, 2'd2, 14, 1'b0};
        tbl[15] = '{2'd2, 2'd0, 1'b0, 1'b0, 2'd2, 15, 1'b0};
        tbl[16] = '{2'd2, 2'd3, 1'b0, 1'b0, 2'd2, 16, 1'b0};
        tbl[17] = '{2'd2, 2'd1, 1'b0, 1'b0, 2'd3, 17, 1'b0};
        tbl[18] = '{2'd2, 2'd2, 1'b0, 1'b0, 2'd3, 18, 1'b0};
        tbl[19] = '{2'd2, 2'd0, 1'b0, 1'b0, 2'd3, 19, 1'b0};
        tbl[20] = '{2'd2, 2'd1, 1'b0, 1'b0, 2'd0, 20, 1'b0};
        tbl[21] = '{2'd2, 2'd2, 1'b0, 1'b0, 2'd0, 21, 1'b0};
        tbl[22] = '{2'd3, 2'd1, 1'b0, 1'b0, 2'd1, 22, 1'b0};
        tbl[23] = '{2'd3, 2'd1, 1'b0, 1'b1, 2'd1, 23, 1'b0};
        tbl[24] = '{2'd3, 2'd2, 1'b1, 1'b0, 2'd2, 24, 1'b1};
        tbl[25] = '{2'd3, 2'd2, 1'b1, 1'b0, 2'd2, 24, 1'b1};
        tbl[26] = '{2'd3, 2'd0, 1'b0, 1'b0, 2'd0, 24, 1'b1};
        tbl[27] = '{2'd3, 2'd0, 1'b0, 1'b1, 2'd0, 27, 1'b0};
        tbl[28] = '{2'd3, 2'd3, 1'b1, 1'b0, 2'd3, 28, 1'b1};
        tbl[29] = '{2'd3, 2'd3, 1'b1, 1'b1, 2'd3, 29, 1'b1};
        tbl[30] = '{2'd3, 2'd1, 1'b0, 1'b0, 2'd1, 29, 1'b1};
        tbl[31] = '{2'd0, 2'd1, 1'b0, 1'b0, 2'd1, 31, 1'b0};
        tbl[32] = '{2'd1, 2'd2, 1'b0, 1'b0, 2'd2, 32, 1'b0};
        tbl[33] = '{2'd3, 2'd2, 1'b0, 1'b0, 2'd2, 33, 1'b0};

        reset = 1'b0;
        mode  = 2'd0;
        sel   = 2'd2;
        trig  = 1'b0;
        rearm = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset disdata", disdata, 32'd0);
        chk("reset cur_ch", {30'd0, cur_ch}, 32'd0);
        chk("reset valid", {31'd0, capture_valid}, 32'd0);
        chk("reset disdata ch3", disdata3, 32'd0);

        @(negedge clk);
        reset = 1'b1;
        base  = cyc;
        for (int i = 0; i < 34; i++) begin
            mode  = tbl[i].mode;
            sel   = tbl[i].sel;
            trig  = tbl[i].trig;
            rearm = tbl[i].rearm;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d disdata", i), disdata, word(tbl[i].ch, base + 32'(tbl[i].smp)));
            chk($sformatf("row%0d cur_ch", i), {30'd0, cur_ch}, {30'd0, tbl[i].ch});
            chk($sformatf("row%0d valid", i), {31'd0, capture_valid}, {31'd0, tbl[i].valid});
            if (tbl[i].mode == 2'd0) begin
                es3 = (tbl[i].sel < 2'd3) ? tbl[i].sel : 2'd0;
                chk($sformatf("row%0d ch3 disdata", i), disdata3, word(es3, base + 32'(i)));
                chk($sformatf("row%0d ch3 cur_ch", i), {30'd0, cur_ch3}, {30'd0, es3});
            end
            @(negedge clk);
        end

        trig  = 1'b0;
        rearm = 1'b0;
        mode  = 2'd2;
        sel   = 2'd1;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async reset disdata", disdata, 32'd0);
        chk("async reset cur_ch", {30'd0, cur_ch}, 32'd0);
        chk("async reset valid", {31'd0, capture_valid}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        base  = cyc;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rescan%0d cur_ch", j), {30'd0, cur_ch}, (j < 3) ? 32'd0 : 32'd1);
            chk($sformatf("rescan%0d disdata", j), disdata,
                word((j < 3) ? 2'd0 : 2'd1, base + 32'(j)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
